// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the cache-to-RAM memory arbiter
//
// Purpose: RAM handshake states, arbiter FSM states and the latched
//          request record shared by mem_arbiter and its testbench.
// Ports:   none (package).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    typedef struct packed {
        arb_op_t op;
        word_t   addr;
        word_t   data;
    } arb_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating icache starvation counter
//
// Purpose: counts dcache grants made while an icache fetch is pending.
// Ports:   clk_i, rst_ni (async active-low), inc_i (count up, saturating),
//          clr_i (clear, wins over inc_i), cnt_o (current count),
//          sat_o (count has reached STARVE_LIMIT).
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          sat_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == CW'(STARVE_LIMIT));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a single-port RAM
//
// Purpose: serves icache reads and dcache reads/writes one at a time on a
//          variable-latency RAM; dcache has priority unless an icache fetch
//          has waited through STARVE_LIMIT dcache grants.
// Ports:   CLK, nRST (async active-low);
//          icache: iREN, iaddr -> iwait, iload;
//          dcache: dREN, dWEN, daddr, dstore -> dwait, dload;
//          RAM:    ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate;
//          ram_err: sticky flag for any ERROR completion.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state_q, state_d;
    arb_req_t          req_q, req_d;
    logic              ram_err_q, ram_err_d;
    logic [DATA_W-1:0] iload_q, iload_d;
    logic [DATA_W-1:0] dload_q, dload_d;
    logic [DATA_W-1:0] load_val;
    logic              d_req, grant_i, grant_d, starve_sat, active;
    logic [CW-1:0]     starve_cnt;
    ramstate_t         rs;

    assign rs    = ramstate_t'(ramstate);
    assign d_req = dREN | dWEN;

    // Grants are only made from IDLE; a saturated starve count lets a
    // pending fetch jump ahead of the dcache.
    assign grant_i = (state_q == IDLE) && iREN && (!d_req || starve_sat);
    assign grant_d = (state_q == IDLE) && d_req && !grant_i;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_starve (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .inc_i  (grant_d && iREN),
        .clr_i  (grant_i || (grant_d && !iREN)),
        .cnt_o  (starve_cnt),
        .sat_o  (starve_sat)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ram_err_d = ram_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        load_val  = '0;
        active    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d    = ISERVE;
                    req_d.op   = OP_READ;
                    req_d.addr = word_t'(iaddr);
                    req_d.data = '0;
                end else if (grant_d) begin
                    state_d    = DSERVE;
                    req_d.op   = dWEN ? OP_WRITE : OP_READ;
                    req_d.addr = word_t'(daddr);
                    req_d.data = word_t'(dstore);
                end
            end
            ISERVE, DSERVE: begin
                // The requester must keep its own request line up; dropping
                // it abandons the service without a completion.
                if (state_q == ISERVE) begin
                    active = iREN;
                end else begin
                    active = (req_q.op == OP_WRITE) ? dWEN : dREN;
                end

                if (!active) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = req_q.addr[ADDR_W-1:0];
                    ramstore = req_q.data[DATA_W-1:0];
                    ramREN   = (req_q.op == OP_READ);
                    ramWEN   = (req_q.op == OP_WRITE);
                    if (rs == ACCESS || rs == ERROR) begin
                        state_d = IDLE;
                        if (rs == ACCESS && req_q.op == OP_READ) begin
                            load_val = ramload;
                        end
                        if (rs == ERROR) begin
                            ram_err_d = 1'b1;
                        end
                        if (state_q == ISERVE) begin
                            iwait = 1'b0;
                        end else begin
                            dwait = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        iload_d = iwait ? iload_q : load_val;
        dload_d = dwait ? dload_q : load_val;
    end

    // Load outputs are live during completion and hold the registered
    // copy of the last completion otherwise.
    assign iload   = iload_d;
    assign dload   = dload_d;
    assign ram_err = ram_err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            req_q     <= '0;
            ram_err_q <= 1'b0;
            iload_q   <= '0;
            dload_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ram_err_q <= ram_err_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int          total = 0;
    int          bad   = 0;
    int          n;
    logic [5:0]  seq;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // reset state
        @(negedge CLK); @(negedge CLK); #1;
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_loads", iload | dload, 32'd0);
        check("rst_ram_err", 32'(ram_err), 32'd0);
        nRST = 1'b1;
        tick;

        // icache read, one-cycle RAM
        iREN = 1'b1; iaddr = 32'h40;
        tick; #1;
        ramstate = ACCESS; ramload = 32'h8C220004; #1;
        check("ird_ramREN", 32'(ramREN), 32'd1);
        check("ird_ramaddr", ramaddr, 32'h40);
        check("ird_iwait", 32'(iwait), 32'd0);
        check("ird_iload", iload, 32'h8C220004);
        check("ird_dwait", 32'(dwait), 32'd1);
        tick; #1;
        check("ird_iwait_after", 32'(iwait), 32'd1);
        check("ird_iload_hold", iload, 32'h8C220004);
        iREN = 1'b0; ramstate = FREE; ramload = 32'h0;

        // conflict: dcache write wins, 2 BUSY cycles, then icache
        tick;
        iREN = 1'b1; iaddr = 32'h80;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
        tick; #1;
        check("cf_ramWEN", 32'(ramWEN), 32'd1);
        check("cf_ramREN", 32'(ramREN), 32'd0);
        check("cf_ramstore", ramstore, 32'hDEADBEEF);
        check("cf_ramaddr", ramaddr, 32'h100);
        check("cf_busy_waits", {30'd0, iwait, dwait}, 32'd3);
        tick; #1;
        check("cf_busy2_dwait", 32'(dwait), 32'd1);
        ramstate = ACCESS; ramload = 32'h77777777; #1;
        check("cf_d_done", {30'd0, iwait, dwait}, 32'd2);
        check("cf_dload_write", dload, 32'd0);
        tick; #1;
        dWEN = 1'b0; ramstate = FREE;
        check("cf_gap_state", 32'(dut.state_q), 32'(IDLE));
        check("cf_gap_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        tick; #1;
        check("cf_i_ramaddr", ramaddr, 32'h80);
        ramstate = ACCESS; ramload = 32'h11112222; #1;
        check("cf_i_done", {30'd0, iwait, dwait}, 32'd1);
        check("cf_iload", iload, 32'h11112222);
        tick; #1;
        iREN = 1'b0; ramstate = FREE;
        tick;

        // starvation: grants D,D,D,D,I,D
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
        ramstate = ACCESS; ramload = 32'h55AA55AA;
        n = 0; seq = '0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick; #1;
            if (!iwait || !dwait) begin
                seq = {seq[4:0], !iwait};
                n++;
            end
        end
        check("starve_count", 32'(n), 32'd6);
        check("starve_seq", 32'(seq), 32'b000010);
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick; #1;
        check("starve_idle", 32'(dut.state_q), 32'(IDLE));

        // ERROR completion
        dREN = 1'b1; daddr = 32'h44; ramstate = ERROR; ramload = 32'hFFFF0000;
        tick; #1;
        check("err_dwait", 32'(dwait), 32'd0);
        check("err_dload", dload, 32'd0);
        check("err_flag_pre", 32'(ram_err), 32'd0);
        tick; #1;
        check("err_flag_set", 32'(ram_err), 32'd1);
        ramstate = ACCESS; ramload = 32'h12345678; daddr = 32'h48;
        tick; #1;
        check("err_good_dload", dload, 32'h12345678);
        check("err_good_dwait", 32'(dwait), 32'd0);
        tick; #1;
        dREN = 1'b0; ramstate = FREE;
        check("err_sticky", 32'(ram_err), 32'd1);
        check("err_dload_hold", dload, 32'h12345678);
        tick;

        // withdrawal
        iREN = 1'b1; iaddr = 32'h60; ramstate = BUSY;
        tick; #1;
        check("wd_ramREN_on", 32'(ramREN), 32'd1);
        iREN = 1'b0; #1;
        check("wd_ramREN_off", 32'(ramREN), 32'd0);
        check("wd_iwait", 32'(iwait), 32'd1);
        tick; #1;
        check("wd_idle", 32'(dut.state_q), 32'(IDLE));
        dREN = 1'b1; daddr = 32'h70; ramstate = ACCESS; ramload = 32'hCAFEF00D;
        tick; #1;
        check("wd_next_dwait", 32'(dwait), 32'd0);
        check("wd_next_dload", dload, 32'hCAFEF00D);
        check("wd_next_addr", ramaddr, 32'h70);
        tick; #1;
        dREN = 1'b0; ramstate = FREE;
        tick;

        // reset in the middle of a DSERVE
        dREN = 1'b1; daddr = 32'h90; ramstate = BUSY;
        tick; #1;
        check("rm_ramREN_pre", 32'(ramREN), 32'd1);
        nRST = 1'b0; #1;
        check("rm_waits", {30'd0, iwait, dwait}, 32'd3);
        check("rm_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        tick; #1;
        nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
        tick; #1;
        check("rm_idle", 32'(dut.state_q), 32'(IDLE));
        check("rm_ram_err", 32'(ram_err), 32'd0);
        check("rm_dload", dload, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
